// File: rtl/int_sched_pkg.sv
// Shared types for the integer issue scheduler: unit classes, op widths and the queued uop payload.
package int_sched_pkg;

  localparam int unsigned BIT_OP_W   = 5;
  localparam int unsigned SHIFT_OP_W = 3;
  // Widest tag a queue entry can hold; the scheduler's TAG_W must not exceed it.
  localparam int unsigned TAG_W_MAX  = 16;

  typedef enum logic [1:0] {
    CLS_ADD   = 2'd0,
    CLS_BIT   = 2'd1,
    CLS_SHIFT = 2'd2
  } unit_cls_e;

  typedef struct packed {
    logic                  valid;
    unit_cls_e             cls;
    logic                  add_op;
    logic [BIT_OP_W-1:0]   bit_op;
    logic [SHIFT_OP_W-1:0] shift_op;
    logic [TAG_W_MAX-1:0]  tag;
  } int_uop_t;

  // Add wins over Shift; anything else, including no class bit at all, goes to Bit.
  function automatic unit_cls_e decode_cls(input logic add_en, input logic shift_en);
    if (add_en) begin
      return CLS_ADD;
    end
    if (shift_en) begin
      return CLS_SHIFT;
    end
    return CLS_BIT;
  endfunction

endpackage

// File: rtl/int_sched_oldest_sel.sv
// Find-first-set over an N-bit mask; bit 0 is the oldest queue slot.
module int_sched_oldest_sel #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     mask,
  output logic             found_c,
  output logic [IDX_W-1:0] idx_c
);

  // Scanning downward leaves the lowest set index as the final assignment.
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        found_c = 1'b1;
        idx_c   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_issue_sched.sv
// Integer issue scheduler: age-ordered compacting queue feeding the Add, Bit and Shift units.
// Defining INT_ISSUE_INORDER_EN restricts issue to the queue head only.
module int_issue_sched
  import int_sched_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TAG_W     = 5,
  parameter int unsigned SHIFT_LAT = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_add_en,
  input  logic                         in_bit_en,
  input  logic                         in_shift_en,
  input  logic                         in_add_op,
  input  logic [BIT_OP_W-1:0]          in_bit_op,
  input  logic [SHIFT_OP_W-1:0]        in_shift_op,
  input  logic [TAG_W-1:0]             in_tag,
  input  logic                         add_rdy,
  input  logic                         bit_rdy,
  output logic                         add_iss_vld,
  output logic                         add_iss_op,
  output logic [TAG_W-1:0]             add_iss_tag,
  output logic                         bit_iss_vld,
  output logic [BIT_OP_W-1:0]          bit_iss_op,
  output logic [TAG_W-1:0]             bit_iss_tag,
  output logic                         sh_iss_vld,
  output logic [SHIFT_OP_W-1:0]        sh_iss_op,
  output logic [TAG_W-1:0]             sh_iss_tag,
  output logic                         sh_busy,
  output logic [$clog2(DEPTH+1)-1:0]   q_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SH_W  = $clog2(SHIFT_LAT + 1);

`ifdef INT_ISSUE_INORDER_EN
  localparam bit IN_ORDER = 1'b1;
`else
  localparam bit IN_ORDER = 1'b0;
`endif

  int_uop_t              q_q [DEPTH];
  int_uop_t              q_d [DEPTH];
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SH_W-1:0]       sh_cnt_q, sh_cnt_d;

  logic                  add_vld_q, add_vld_d;
  logic                  add_op_q, add_op_d;
  logic [TAG_W-1:0]      add_tag_q, add_tag_d;
  logic                  bit_vld_q, bit_vld_d;
  logic [BIT_OP_W-1:0]   bit_op_q, bit_op_d;
  logic [TAG_W-1:0]      bit_tag_q, bit_tag_d;
  logic                  sh_vld_q, sh_vld_d;
  logic [SHIFT_OP_W-1:0] sh_op_q, sh_op_d;
  logic [TAG_W-1:0]      sh_tag_q, sh_tag_d;

  logic [DEPTH-1:0]      add_mask, bit_mask, sh_mask, rm_mask;
  logic                  add_found, bit_found, sh_found;
  logic [IDX_W-1:0]      add_idx, bit_idx, sh_idx;
  logic                  iss_add, iss_bit, iss_sh, sh_free, enq;
  logic [CNT_W-1:0]      n_iss, wr_ptr;
  int_uop_t              new_uop;
  logic                  unused_bit_en;

  // Class is fully decoded from Add/Shift; the Bit enable is redundant.
  assign unused_bit_en = in_bit_en;

  assign in_ready = (cnt_q < CNT_W'(DEPTH));
  assign enq      = in_valid && in_ready && !flush;

  // Per-unit candidate masks; in-order mode only exposes the head entry.
  always_comb begin
    add_mask = '0;
    bit_mask = '0;
    sh_mask  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (q_q[i].valid && (!IN_ORDER || i == 0)) begin
        add_mask[i] = (q_q[i].cls == CLS_ADD);
        bit_mask[i] = (q_q[i].cls == CLS_BIT);
        sh_mask[i]  = (q_q[i].cls == CLS_SHIFT);
      end
    end
  end

  int_sched_oldest_sel #(.N(DEPTH), .IDX_W(IDX_W)) u_sel_add (
    .mask(add_mask), .found_c(add_found), .idx_c(add_idx)
  );
  int_sched_oldest_sel #(.N(DEPTH), .IDX_W(IDX_W)) u_sel_bit (
    .mask(bit_mask), .found_c(bit_found), .idx_c(bit_idx)
  );
  int_sched_oldest_sel #(.N(DEPTH), .IDX_W(IDX_W)) u_sel_sh (
    .mask(sh_mask), .found_c(sh_found), .idx_c(sh_idx)
  );

  // The Shift unit frees up at this edge when the counter is at 1, so issues land SHIFT_LAT apart.
  assign sh_free = (sh_cnt_q <= SH_W'(1));
  assign iss_add = add_found && add_rdy && !flush;
  assign iss_bit = bit_found && bit_rdy && !flush;
  assign iss_sh  = sh_found && sh_free && !flush;
  assign n_iss   = CNT_W'(iss_add) + CNT_W'(iss_bit) + CNT_W'(iss_sh);

  always_comb begin
    new_uop          = '0;
    new_uop.valid    = 1'b1;
    new_uop.cls      = decode_cls(in_add_en, in_shift_en);
    new_uop.add_op   = in_add_op;
    new_uop.bit_op   = in_bit_op;
    new_uop.shift_op = in_shift_op;
    new_uop.tag      = TAG_W_MAX'(in_tag);
  end

  // Remove issued entries, compact survivors toward slot 0, then append the new uop.
  always_comb begin
    for (int k = 0; k < int'(DEPTH); k++) begin
      q_d[k] = '0;
    end
    rm_mask = '0;
    wr_ptr  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      rm_mask[i] = (iss_add && add_idx == IDX_W'(i)) ||
                   (iss_bit && bit_idx == IDX_W'(i)) ||
                   (iss_sh  && sh_idx  == IDX_W'(i));
      if (q_q[i].valid && !rm_mask[i]) begin
        q_d[IDX_W'(wr_ptr)] = q_q[i];
        wr_ptr              = wr_ptr + CNT_W'(1);
      end
    end
    if (enq) begin
      q_d[IDX_W'(wr_ptr)] = new_uop;
    end
    if (flush) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        q_d[k] = '0;
      end
    end
  end

  assign cnt_d = flush ? '0 : (cnt_q + CNT_W'(enq) - n_iss);

  // Flush leaves the counter running: an op already in the Shift unit still completes.
  always_comb begin
    sh_cnt_d = sh_cnt_q;
    if (iss_sh) begin
      sh_cnt_d = SH_W'(SHIFT_LAT);
    end else if (sh_cnt_q != '0) begin
      sh_cnt_d = sh_cnt_q - SH_W'(1);
    end
  end

  // Issue registers: op/tag hold their last value, valid is a one-cycle pulse.
  always_comb begin
    add_vld_d = iss_add;
    add_op_d  = add_op_q;
    add_tag_d = add_tag_q;
    bit_vld_d = iss_bit;
    bit_op_d  = bit_op_q;
    bit_tag_d = bit_tag_q;
    sh_vld_d  = iss_sh;
    sh_op_d   = sh_op_q;
    sh_tag_d  = sh_tag_q;
    if (iss_add) begin
      add_op_d  = q_q[add_idx].add_op;
      add_tag_d = TAG_W'(q_q[add_idx].tag);
    end
    if (iss_bit) begin
      bit_op_d  = q_q[bit_idx].bit_op;
      bit_tag_d = TAG_W'(q_q[bit_idx].tag);
    end
    if (iss_sh) begin
      sh_op_d  = q_q[sh_idx].shift_op;
      sh_tag_d = TAG_W'(q_q[sh_idx].tag);
    end
  end

  generate
    if (TAG_W < TAG_W_MAX) begin : g_tag_sink
      logic unused_tag_hi;
      always_comb begin
        unused_tag_hi = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
          unused_tag_hi = unused_tag_hi ^ (^q_q[i].tag[TAG_W_MAX-1:TAG_W]);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        q_q[k] <= '0;
      end
      cnt_q     <= '0;
      sh_cnt_q  <= '0;
      add_vld_q <= 1'b0;
      add_op_q  <= 1'b0;
      add_tag_q <= '0;
      bit_vld_q <= 1'b0;
      bit_op_q  <= '0;
      bit_tag_q <= '0;
      sh_vld_q  <= 1'b0;
      sh_op_q   <= '0;
      sh_tag_q  <= '0;
    end else begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        q_q[k] <= q_d[k];
      end
      cnt_q     <= cnt_d;
      sh_cnt_q  <= sh_cnt_d;
      add_vld_q <= add_vld_d;
      add_op_q  <= add_op_d;
      add_tag_q <= add_tag_d;
      bit_vld_q <= bit_vld_d;
      bit_op_q  <= bit_op_d;
      bit_tag_q <= bit_tag_d;
      sh_vld_q  <= sh_vld_d;
      sh_op_q   <= sh_op_d;
      sh_tag_q  <= sh_tag_d;
    end
  end

  assign add_iss_vld = add_vld_q;
  assign add_iss_op  = add_op_q;
  assign add_iss_tag = add_tag_q;
  assign bit_iss_vld = bit_vld_q;
  assign bit_iss_op  = bit_op_q;
  assign bit_iss_tag = bit_tag_q;
  assign sh_iss_vld  = sh_vld_q;
  assign sh_iss_op   = sh_op_q;
  assign sh_iss_tag  = sh_tag_q;
  assign sh_busy     = (sh_cnt_q != '0);
  assign q_count     = cnt_q;

endmodule

// File: tb/tb_int_issue_sched.sv
// Directed bench for int_issue_sched with hand-computed expectations (DEPTH=4, TAG_W=5, SHIFT_LAT=3).
module tb_int_issue_sched;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned TAG_W     = 5;
  localparam int unsigned SHIFT_LAT = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_add_en = 1'b0;
  logic             in_bit_en = 1'b0;
  logic             in_shift_en = 1'b0;
  logic             in_add_op = 1'b0;
  logic [4:0]       in_bit_op = '0;
  logic [2:0]       in_shift_op = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             add_rdy = 1'b0;
  logic             bit_rdy = 1'b0;
  logic             add_iss_vld, add_iss_op;
  logic [TAG_W-1:0] add_iss_tag;
  logic             bit_iss_vld;
  logic [4:0]       bit_iss_op;
  logic [TAG_W-1:0] bit_iss_tag;
  logic             sh_iss_vld;
  logic [2:0]       sh_iss_op;
  logic [TAG_W-1:0] sh_iss_tag;
  logic             sh_busy;
  logic [2:0]       q_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  int_issue_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W), .SHIFT_LAT(SHIFT_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_add_en(in_add_en), .in_bit_en(in_bit_en), .in_shift_en(in_shift_en),
    .in_add_op(in_add_op), .in_bit_op(in_bit_op), .in_shift_op(in_shift_op),
    .in_tag(in_tag), .add_rdy(add_rdy), .bit_rdy(bit_rdy),
    .add_iss_vld(add_iss_vld), .add_iss_op(add_iss_op), .add_iss_tag(add_iss_tag),
    .bit_iss_vld(bit_iss_vld), .bit_iss_op(bit_iss_op), .bit_iss_tag(bit_iss_tag),
    .sh_iss_vld(sh_iss_vld), .sh_iss_op(sh_iss_op), .sh_iss_tag(sh_iss_tag),
    .sh_busy(sh_busy), .q_count(q_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic a, input logic b, input logic s, input logic aop,
                      input logic [4:0] bop, input logic [2:0] sop, input logic [TAG_W-1:0] tg);
    in_valid    = 1'b1;
    in_add_en   = a;
    in_bit_en   = b;
    in_shift_en = s;
    in_add_op   = aop;
    in_bit_op   = bop;
    in_shift_op = sop;
    in_tag      = tg;
  endtask

  task automatic idle();
    in_valid    = 1'b0;
    in_add_en   = 1'b0;
    in_bit_en   = 1'b0;
    in_shift_en = 1'b0;
    in_add_op   = 1'b0;
    in_bit_op   = '0;
    in_shift_op = '0;
    in_tag      = '0;
  endtask

  logic [10:0] exp_sh;
  logic [10:0] exp_add;
  int          exp_cnt;
  int          exp_busy;

  initial begin
    // Test 1: reset state, then one uop per unit
    idle();
    add_rdy = 1'b1;
    bit_rdy = 1'b1;
    repeat (2) tick();
    check("rst_q_count", 32'(q_count), 0);
    check("rst_add_vld", 32'(add_iss_vld), 0);
    check("rst_sh_busy", 32'(sh_busy), 0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 32'(in_ready), 1);

    push(1'b1, 1'b0, 1'b0, 1'b1, 5'b00000, 3'b000, 5'd1);
    tick();
    push(1'b0, 1'b1, 1'b0, 1'b0, 5'b00001, 3'b000, 5'd2);
    check("t1_no_bypass", 32'(add_iss_vld), 0);
    tick();
    push(1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 3'b001, 5'd3);
    check("t1_add_vld", 32'(add_iss_vld), 1);
    check("t1_add_tag", 32'(add_iss_tag), 1);
    check("t1_add_op", 32'(add_iss_op), 1);
    tick();
    idle();
    check("t1_bit_vld", 32'(bit_iss_vld), 1);
    check("t1_bit_tag", 32'(bit_iss_tag), 2);
    check("t1_bit_op", 32'(bit_iss_op), 1);
    check("t1_add_pulse_end", 32'(add_iss_vld), 0);
    tick();
    check("t1_sh_vld", 32'(sh_iss_vld), 1);
    check("t1_sh_tag", 32'(sh_iss_tag), 3);
    check("t1_sh_op", 32'(sh_iss_op), 1);
    check("t1_bit_pulse_end", 32'(bit_iss_vld), 0);
    check("t1_q_empty", 32'(q_count), 0);
    check("t1_sh_busy", 32'(sh_busy), 1);
    repeat (4) tick();
    check("t1_sh_idle", 32'(sh_busy), 0);

    // Test 2: three Shifts then an Add; Shift pulses SHIFT_LAT cycles apart
    exp_sh = 11'b001_0010_0100;
`ifdef INT_ISSUE_INORDER_EN
    exp_add = 11'b010_0000_0000;
`else
    exp_add = 11'b000_0010_0000;
`endif
    for (int c = 0; c < 11; c++) begin
      case (c)
        0:       push(1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 3'b001, 5'd4);
        1:       push(1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 3'b010, 5'd5);
        2:       push(1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 3'b100, 5'd6);
        3:       push(1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 5'd7);
        default: idle();
      endcase
      check($sformatf("t2_sh_vld_c%0d", c), 32'(sh_iss_vld), 32'(exp_sh[c]));
      if (exp_sh[c]) begin
        check($sformatf("t2_sh_tag_c%0d", c), 32'(sh_iss_tag), 32'(4 + (c - 2) / 3));
        check($sformatf("t2_sh_op_c%0d", c), 32'(sh_iss_op), 32'(1 << ((c - 2) / 3)));
      end
      check($sformatf("t2_add_vld_c%0d", c), 32'(add_iss_vld), 32'(exp_add[c]));
      if (exp_add[c]) begin
        check("t2_add_tag", 32'(add_iss_tag), 7);
      end
      tick();
    end
    repeat (2) tick();
    check("t2_q_empty", 32'(q_count), 0);

    // Test 3: full queue back-pressure
    add_rdy = 1'b0;
    bit_rdy = 1'b0;
    push(1'b1, 1'b0, 1'b0, 1'b1, 5'b00000, 3'b000, 5'd8);
    tick();
    push(1'b0, 1'b1, 1'b0, 1'b0, 5'b00010, 3'b000, 5'd9);
    tick();
    push(1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 5'd10);
    tick();
    push(1'b0, 1'b1, 1'b0, 1'b0, 5'b00100, 3'b000, 5'd11);
    tick();
    push(1'b1, 1'b0, 1'b0, 1'b1, 5'b00000, 3'b000, 5'd12);
    check("t3_full_count", 32'(q_count), 4);
    check("t3_full_not_ready", 32'(in_ready), 0);
    tick();
    idle();
    add_rdy = 1'b1;
    check("t3_fifth_dropped", 32'(q_count), 4);
    check("t3_no_issue_credit", 32'(in_ready), 0);
    tick();
    check("t3_count_drop", 32'(q_count), 3);
    check("t3_ready_back", 32'(in_ready), 1);
    check("t3_add_vld", 32'(add_iss_vld), 1);
    check("t3_add_tag", 32'(add_iss_tag), 8);
    tick();
`ifdef INT_ISSUE_INORDER_EN
    exp_cnt = 3;
`else
    exp_cnt = 2;
    check("t3_add2_tag", 32'(add_iss_tag), 10);
`endif
    check("t3_count_after2", 32'(q_count), 32'(exp_cnt));
    bit_rdy = 1'b1;
    repeat (5) tick();
    check("t3_drained", 32'(q_count), 0);

    // Test 4: flush with entries queued and a Shift in flight
    add_rdy = 1'b0;
    bit_rdy = 1'b0;
    push(1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 5'd14);
    tick();
    push(1'b0, 1'b1, 1'b0, 1'b0, 5'b00001, 3'b000, 5'd15);
    tick();
    push(1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 5'd16);
    tick();
    push(1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 3'b001, 5'd13);
    tick();
    idle();
    tick();
`ifdef INT_ISSUE_INORDER_EN
    exp_cnt  = 4;
    exp_busy = 0;
`else
    exp_cnt  = 3;
    exp_busy = 1;
    check("t4_sh_vld", 32'(sh_iss_vld), 1);
    check("t4_sh_tag", 32'(sh_iss_tag), 13);
`endif
    check("t4_pre_count", 32'(q_count), 32'(exp_cnt));
    push(1'b1, 1'b0, 1'b0, 1'b1, 5'b00000, 3'b000, 5'd17);
    flush   = 1'b1;
    add_rdy = 1'b1;
    bit_rdy = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    check("t4_flush_count", 32'(q_count), 0);
    check("t4_flush_add_vld", 32'(add_iss_vld), 0);
    check("t4_flush_bit_vld", 32'(bit_iss_vld), 0);
    check("t4_flush_sh_vld", 32'(sh_iss_vld), 0);
    check("t4_busy_kept", 32'(sh_busy), 32'(exp_busy));
    tick();
    check("t4_input_lost", 32'(q_count), 0);
    check("t4_no_add_after", 32'(add_iss_vld), 0);
    check("t4_busy_still", 32'(sh_busy), 32'(exp_busy));
    tick();
    check("t4_busy_done", 32'(sh_busy), 0);

    // Test 5: asynchronous reset while a pulse is high
    push(1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 3'b001, 5'd19);
    tick();
    push(1'b1, 1'b0, 1'b0, 1'b1, 5'b00000, 3'b000, 5'd20);
    tick();
    idle();
    tick();
    check("t5_add_vld_pre", 32'(add_iss_vld), 1);
    check("t5_busy_pre", 32'(sh_busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_add_vld", 32'(add_iss_vld), 0);
    check("t5_rst_add_tag", 32'(add_iss_tag), 0);
    check("t5_rst_add_op", 32'(add_iss_op), 0);
    check("t5_rst_sh_tag", 32'(sh_iss_tag), 0);
    check("t5_rst_sh_busy", 32'(sh_busy), 0);
    check("t5_rst_count", 32'(q_count), 0);
    #2;
    rst_n = 1'b1;
    tick();

    // Test 6: classless uop goes to the Bit unit
    bit_rdy = 1'b1;
    push(1'b0, 1'b0, 1'b0, 1'b0, 5'b10000, 3'b000, 5'd21);
    tick();
    idle();
    check("t6_no_bypass", 32'(bit_iss_vld), 0);
    tick();
    check("t6_bit_vld", 32'(bit_iss_vld), 1);
    check("t6_bit_op", 32'(bit_iss_op), 32'h10);
    check("t6_bit_tag", 32'(bit_iss_tag), 21);
    check("t6_add_vld", 32'(add_iss_vld), 0);
    check("t6_sh_vld", 32'(sh_iss_vld), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
